// File: rtl/sweep_pkg.sv
// Shared encodings and payload types for the frequency sweep controller.
package sweep_pkg;

    localparam int unsigned FREQ_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [1:0] MODE_SINGLE = 2'b00;
    localparam logic [1:0] MODE_REPEAT = 2'b01;
    localparam logic [1:0] MODE_TRI    = 2'b10;

    typedef struct packed {
        logic [FREQ_W-1:0] f_start;
        logic [FREQ_W-1:0] f_stop;
        logic [FREQ_W-1:0] f_step;
    } sweep_cfg_t;

endpackage

// File: rtl/sweep_next_freq.sv
// Combinational next sweep point: 33-bit step toward a destination, clamped, plus end detect.
module sweep_next_freq
    import sweep_pkg::*;
(
    input  logic [FREQ_W-1:0] cur,
    input  logic [FREQ_W-1:0] target,
    input  logic [FREQ_W-1:0] other,
    input  logic [FREQ_W-1:0] step,
    input  logic              bounce,
    output logic [FREQ_W-1:0] nxt,
    output logic              at_end
);

    logic [FREQ_W-1:0] dest;
    logic [FREQ_W:0]   sum;
    logic [FREQ_W:0]   diff;

    always_comb begin
        at_end = (cur == target);
        // At an end point a bouncing sweep heads back toward the opposite end.
        dest   = (at_end && bounce) ? other : target;
        sum    = {1'b0, cur} + {1'b0, step};
        diff   = {1'b0, cur} - {1'b0, step};
        nxt    = dest;
        if (dest >= cur) begin
            if ((step != '0) && (sum < {1'b0, dest}))
                nxt = sum[FREQ_W-1:0];
        end else begin
            if ((step != '0) && !diff[FREQ_W] && (diff[FREQ_W-1:0] > dest))
                nxt = diff[FREQ_W-1:0];
        end
    end

endmodule

// File: rtl/sweep_ctrl.sv
// Frequency sweep controller: steps a frequency word between two end points with a per-point dwell.
module sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int unsigned DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [FREQ_W-1:0]  f_start,
    input  logic [FREQ_W-1:0]  f_stop,
    input  logic [FREQ_W-1:0]  f_step,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [1:0]         mode,
    output logic [FREQ_W-1:0]  freq,
    output logic               step_strobe,
    output logic               busy,
    output logic               done
);

    state_t             state, state_nxt;
    sweep_cfg_t         cfg, cfg_nxt;
    logic [DWELL_W-1:0] dwell_q, dwell_nxt;
    logic [1:0]         mode_q, mode_nxt;
    logic               toward_stop, toward_stop_nxt;
    logic [DWELL_W-1:0] cnt, cnt_nxt;
    logic [FREQ_W-1:0]  freq_nxt;
    logic               strobe_nxt;
    logic               done_nxt;

    logic [FREQ_W-1:0]  target_c;
    logic [FREQ_W-1:0]  other_c;
    logic [FREQ_W-1:0]  step_freq_c;
    logic               at_end_c;
    logic               expire_c;

    assign target_c = toward_stop ? cfg.f_stop  : cfg.f_start;
    assign other_c  = toward_stop ? cfg.f_start : cfg.f_stop;
    // A zero dwell behaves as a one-cycle dwell.
    assign expire_c = (dwell_q == '0) || (cnt == dwell_q - DWELL_W'(1));

    sweep_next_freq u_next (
        .cur    (freq),
        .target (target_c),
        .other  (other_c),
        .step   (cfg.f_step),
        .bounce (mode_q == MODE_TRI),
        .nxt    (step_freq_c),
        .at_end (at_end_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cfg         <= '0;
            dwell_q     <= '0;
            mode_q      <= MODE_SINGLE;
            toward_stop <= 1'b1;
            cnt         <= '0;
            freq        <= '0;
            step_strobe <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            cfg         <= cfg_nxt;
            dwell_q     <= dwell_nxt;
            mode_q      <= mode_nxt;
            toward_stop <= toward_stop_nxt;
            cnt         <= cnt_nxt;
            freq        <= freq_nxt;
            step_strobe <= strobe_nxt;
            busy        <= (state_nxt == RUN);
            done        <= done_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        cfg_nxt         = cfg;
        dwell_nxt       = dwell_q;
        mode_nxt        = mode_q;
        toward_stop_nxt = toward_stop;
        cnt_nxt         = cnt;
        freq_nxt        = freq;
        strobe_nxt      = 1'b0;
        done_nxt        = 1'b0;

        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    cfg_nxt         = '{f_start: f_start, f_stop: f_stop, f_step: f_step};
                    dwell_nxt       = dwell;
                    mode_nxt        = mode;
                    toward_stop_nxt = 1'b1;
                    cnt_nxt         = '0;
                    freq_nxt        = f_start;
                    strobe_nxt      = 1'b1;
                    state_nxt       = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (expire_c) begin
                    cnt_nxt    = '0;
                    strobe_nxt = 1'b1;
                    if (!at_end_c) begin
                        freq_nxt = step_freq_c;
                    end else if (mode_q == MODE_REPEAT) begin
                        freq_nxt = cfg.f_start;
                    end else if (mode_q == MODE_TRI) begin
                        freq_nxt        = step_freq_c;
                        toward_stop_nxt = !toward_stop;
                    end else begin
                        strobe_nxt = 1'b0;
                        done_nxt   = 1'b1;
                        state_nxt  = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + DWELL_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sweep_ctrl.sv
// Directed bench for sweep_ctrl with hand-computed sweep point sequences.
module tb_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [31:0] f_start, f_stop, f_step;
    logic [15:0] dwell;
    logic [1:0]  mode;
    logic [31:0] freq;
    logic        step_strobe, busy, done;

    int checks = 0;
    int errors = 0;

    sweep_ctrl #(.DWELL_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .f_start     (f_start),
        .f_stop      (f_stop),
        .f_step      (f_step),
        .dwell       (dwell),
        .mode        (mode),
        .freq        (freq),
        .step_strobe (step_strobe),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Set config and pulse start for one edge; afterwards the first point is visible.
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic [31:0] s,
                          input logic [15:0] d, input logic [1:0] m);
        f_start = a; f_stop = b; f_step = s; dwell = d; mode = m;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Expect one sweep point held for n cycles, strobe on its first cycle only.
    task automatic pt(input string tag, input logic [31:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_freq"}, freq, f);
            chk({tag, "_strobe"}, 32'(step_strobe), 32'(i == 0));
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            tick();
        end
    endtask

    task automatic expect_done(input string tag, input logic [31:0] f);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_freq"}, freq, f);
        chk({tag, "_strobe"}, 32'(step_strobe), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        f_start = '0; f_stop = '0; f_step = '0; dwell = '0; mode = 2'b00;
        tick(); tick();
        chk("rst_freq", freq, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_strobe", 32'(step_strobe), 32'd0);
        rst = 1'b0;
        tick();

        // single up, dwell 3
        launch(32'd100, 32'd130, 32'd10, 16'd3, 2'b00);
        pt("up100", 32'd100, 3);
        pt("up110", 32'd110, 3);
        pt("up120", 32'd120, 3);
        pt("up130", 32'd130, 3);
        expect_done("up_end", 32'd130);
        tick();
        chk("up_done_pulse", 32'(done), 32'd0);
        chk("up_hold", freq, 32'd130);

        // down with clamp at the stop point
        launch(32'd100, 32'd75, 32'd10, 16'd1, 2'b00);
        pt("dn100", 32'd100, 1);
        pt("dn90", 32'd90, 1);
        pt("dn80", 32'd80, 1);
        pt("dn75", 32'd75, 1);
        expect_done("dn_end", 32'd75);
        tick();

        // triangle, then abort at the top
        launch(32'd0, 32'd20, 32'd10, 16'd1, 2'b10);
        pt("tr0", 32'd0, 1);
        pt("tr10", 32'd10, 1);
        pt("tr20", 32'd20, 1);
        pt("tr10b", 32'd10, 1);
        pt("tr0b", 32'd0, 1);
        pt("tr10c", 32'd10, 1);
        chk("tr20c_freq", freq, 32'd20);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("tr_abort_busy", 32'(busy), 32'd0);
        chk("tr_abort_done", 32'(done), 32'd0);
        chk("tr_abort_freq", freq, 32'd20);
        tick();
        chk("tr_abort_done2", 32'(done), 32'd0);
        chk("tr_abort_freq2", freq, 32'd20);

        // repeat near the top of the 32-bit range
        launch(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h10, 16'd2, 2'b01);
        pt("rp_lo", 32'hFFFF_FFF0, 2);
        pt("rp_hi", 32'hFFFF_FFFF, 2);
        pt("rp_lo2", 32'hFFFF_FFF0, 2);
        pt("rp_hi2", 32'hFFFF_FFFF, 2);
        chk("rp_lo3", freq, 32'hFFFF_FFF0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("rp_abort_busy", 32'(busy), 32'd0);
        chk("rp_abort_done", 32'(done), 32'd0);
        tick();

        // dwell 0 and step 0
        launch(32'd5, 32'd50, 32'd0, 16'd0, 2'b00);
        pt("z5", 32'd5, 1);
        pt("z50", 32'd50, 1);
        expect_done("z_end", 32'd50);
        tick();

        // start together with abort in IDLE is ignored
        f_start = 32'd1; f_stop = 32'd2; f_step = 32'd1; dwell = 16'd1; mode = 2'b00;
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("sa_busy", 32'(busy), 32'd0);
        chk("sa_strobe", 32'(step_strobe), 32'd0);
        chk("sa_freq", freq, 32'd50);
        tick();

        // start while busy ignored, inputs changing mid-run ignored, start on done accepted
        launch(32'd1000, 32'd1001, 32'd1, 16'd4, 2'b00);
        f_start = 32'd7; f_stop = 32'd9; f_step = 32'd1; dwell = 16'd1; mode = 2'b01;
        start = 1'b1;
        pt("sb1000", 32'd1000, 4);
        pt("sb1001", 32'd1001, 4);
        expect_done("sb_end", 32'd1001);
        tick();
        start = 1'b0;
        pt("rs7", 32'd7, 1);
        pt("rs8", 32'd8, 1);
        pt("rs9", 32'd9, 1);
        pt("rs7b", 32'd7, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();

        // reset mid-sweep, then a normal run
        launch(32'd100, 32'd130, 32'd10, 16'd3, 2'b00);
        pt("mr100", 32'd100, 3);
        chk("mr110", freq, 32'd110);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_freq", freq, 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_done", 32'(done), 32'd0);
        chk("mr_strobe", 32'(step_strobe), 32'd0);
        tick();
        chk("mr_idle", 32'(busy), 32'd0);
        launch(32'd1, 32'd3, 32'd1, 16'd1, 2'b00);
        pt("ar1", 32'd1, 1);
        pt("ar2", 32'd2, 1);
        pt("ar3", 32'd3, 1);
        expect_done("ar_end", 32'd3);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sweep_ctrl.md
SWEEP_CTRL -- requirements
Module: sweep_ctrl

Interface
REQ-001 Parameter DWELL_W, default 16, width of the dwell counter and the dwell input.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 start  in  1  sweep request, sampled every cycle.
REQ-005 abort  in  1  terminate sweep, sampled every cycle.
REQ-006 f_start  in  32  first frequency word, unsigned.
REQ-007 f_stop  in  32  last frequency word, unsigned.
REQ-008 f_step  in  32  increment magnitude, unsigned.
REQ-009 dwell  in  DWELL_W  cycles each point is held.
REQ-010 mode  in  2  00 single, 01 repeat (sawtooth), 10 triangle, 11 treated as single.
REQ-011 freq  out  32  frequency word for the tone generator's freq input, registered.
REQ-012 step_strobe  out  1  high in the first cycle a new freq value is visible.
REQ-013 busy  out  1  sweep in progress.
REQ-014 done  out  1  one-cycle pulse on normal completion.

Function
REQ-015 FSM states SHALL be IDLE and RUN; done is a registered pulse issued on the RUN->IDLE completion transition.
REQ-016 In IDLE, start=1 with abort=0 SHALL latch f_start, f_stop, f_step, dwell and mode; the next cycle freq=f_start, step_strobe=1, busy=1, state RUN.
REQ-017 Sweep direction SHALL be up when f_stop >= f_start, else down, and is fixed at start except in triangle mode.
REQ-018 Each point SHALL be held for exactly dwell cycles; dwell=0 SHALL be treated as 1.
REQ-019 On dwell expiry at a non-end point, next freq SHALL be freq +/- f_step computed in 33 bits and clamped to the end point when it reaches or passes it; no 32-bit wrap is permitted.
REQ-020 f_step=0 SHALL make the next point equal to the current end point.
REQ-021 On dwell expiry at f_stop: single -> IDLE with busy=0, done=1 for one cycle, freq holding f_stop; repeat -> freq=f_start; triangle -> direction reverses toward f_start.
REQ-022 In triangle mode, dwell expiry at f_start on the return leg SHALL reverse toward f_stop again; each endpoint is dwelled once per visit.
REQ-023 f_start==f_stop SHALL give one dwell then done in single mode; in repeat and triangle it SHALL re-dwell indefinitely, with step_strobe pulsing once per dwell.
REQ-024 abort=1 in RUN SHALL return the FSM to IDLE next cycle with busy=0, done=0, freq holding its last value.
REQ-025 start and abort both high in IDLE: abort wins and start is ignored.
REQ-026 start while busy SHALL be ignored; start in the cycle done=1 SHALL be accepted.
REQ-027 Latched configuration SHALL be unaffected by input changes during RUN.

Reset
REQ-028 rst=1 SHALL force, on the next edge, IDLE, freq=0, step_strobe=0, busy=0, done=0, dwell counter=0; it has priority over start and abort, including mid-sweep.

Structure
REQ-029 Package sweep_pkg SHALL hold the state encoding, mode encodings (MODE_SINGLE, MODE_REPEAT, MODE_TRI) and the 32-bit frequency width constant.
REQ-030 One sub-module, sweep_next_freq (combinational 33-bit step, clamp and end-point detect), SHALL be instantiated; counters and FSM remain in sweep_ctrl.

Verification
REQ-031 Single up: start=100, stop=130, step=10, dwell=3, start at cycle 0 -> freq 100/110/120/130 in cycles 1-3/4-6/7-9/10-12, four step_strobe pulses, done=1 and busy=0 at cycle 13.
REQ-032 Down with clamp: start=100, stop=75, step=10, dwell=1 -> freq 100, 90, 80, 75, then a done pulse.
REQ-033 Triangle: start=0, stop=20, step=10, dwell=1 -> 0, 10, 20, 10, 0, 10, ...; abort at freq=20 -> busy=0 next cycle, freq stays 20, no done.
REQ-034 Repeat near max: start=0xFFFFFFF0, stop=0xFFFFFFFF, step=0x10, dwell=2 -> 0xFFFFFFF0, 0xFFFFFFFF (clamped), 0xFFFFFFF0, ...; no wrap to small values.
REQ-035 Edges: dwell=0 holds each point 1 cycle; step=0 jumps f_start->f_stop; start+abort in IDLE is ignored; start while busy is ignored.
REQ-036 rst=1 mid-sweep -> next cycle freq=0, busy=0, done=0; start after reset runs normally.
